// File: rtl/apb_pkg.sv
// Shared APB types and register map for the encoder/decoder register file.
// Address constants are byte addresses on the 20-bit APB address bus.
package apb_pkg;

    localparam int APB_ADDR_W = 20;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    localparam logic [APB_ADDR_W-1:0] CTRL_ADDR           = 20'h00000;
    localparam logic [APB_ADDR_W-1:0] DATA_IN_ADDR        = 20'h00004;
    localparam logic [APB_ADDR_W-1:0] CODEWORD_WIDTH_ADDR = 20'h00008;
    localparam logic [APB_ADDR_W-1:0] NOISE_ADDR          = 20'h0000C;

endpackage

// File: rtl/apb_requester.sv
// APB initiator: one command at a time, SETUP->ACCESS, 3-cycle zero-wait latency, optional timeout.
// Backpressure: cmd_ready only in IDLE; rsp_valid is a one-cycle strobe with no backpressure.
module apb_requester
    import apb_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_error,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       PREADY
);

    localparam int            TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            TMO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};

    apb_state_t                 state_q,     state_d;
    logic [TW-1:0]              timer_q,     timer_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_error_q, rsp_error_d;
    logic                       psel_q,      psel_d;
    logic                       penable_q,   penable_d;
    logic                       pwrite_q,    pwrite_d;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [AMBA_WORD-1:0]       pwdata_q,    pwdata_d;
    logic                       tmo_hit;

    assign tmo_hit = TMO_EN && (timer_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;

        case (state_q)
            APB_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    state_d     = APB_SETUP;
                    timer_d     = '0;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                end
            end
            APB_SETUP: begin
                state_d   = APB_ACCESS;
                penable_d = 1'b1;
            end
            APB_ACCESS: begin
                // A slave that answers in the timeout cycle still wins over the abort.
                if (PREADY || tmo_hit) begin
                    state_d     = APB_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = !PREADY;
                    rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d     = APB_IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= APB_IDLE;
            timer_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule
